// File: rtl/tcam_update_engine.sv
// Update engine for the SRL32-based fractured TCAM: expands N ternary entries
// into 32-deep per-block match bitmaps, then streams them into one lookup slice.
module tcam_update_engine #(
  parameter int unsigned TCAM_WIDTH        = 40,
  parameter int unsigned TCAM_DEPTH        = 512,
  parameter int unsigned ENTRIES_PER_SLICE = 8,
  parameter int unsigned SLICE_SEL_WIDTH   = 6
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [TCAM_WIDTH-1:0]                            search_key,
  input  logic                                             req_valid,
  output logic                                             req_ready,
  input  logic [TCAM_WIDTH*ENTRIES_PER_SLICE-1:0]          req_data,
  input  logic [TCAM_WIDTH*ENTRIES_PER_SLICE-1:0]          req_keep,
  input  logic [ENTRIES_PER_SLICE-1:0]                     req_entry_valid,
  input  logic [SLICE_SEL_WIDTH-1:0]                       req_slice,
  output logic [TCAM_WIDTH-1:0]                            wr_addr,
  output logic [(TCAM_WIDTH/5)*ENTRIES_PER_SLICE-1:0]      wr_data_in,
  output logic [TCAM_DEPTH/ENTRIES_PER_SLICE-1:0]          wr_enable_oh,
  output logic                                             busy,
  output logic                                             done,
  output logic                                             error
);

  localparam int unsigned B  = TCAM_WIDTH / 5;
  localparam int unsigned N  = ENTRIES_PER_SLICE;
  localparam int unsigned S  = TCAM_DEPTH / N;
  localparam int unsigned EW = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic [4:0]              k;
  logic [EW-1:0]           e;
  logic [TCAM_WIDTH*N-1:0] data_q;
  logic [TCAM_WIDTH*N-1:0] keep_q;
  logic [N-1:0]            ev_q;
  logic [SLICE_SEL_WIDTH-1:0] slice_q;
  logic [31:0]             stage [B*N];

  logic [TCAM_WIDTH-1:0]   cur_data;
  logic [TCAM_WIDTH-1:0]   cur_keep;
  logic                    cur_ev;
  logic [B-1:0]            blk_match;
  logic                    accept;
  logic                    k_last;
  logic                    e_last;

  assign accept = (state == ST_IDLE) && req_valid;
  assign k_last = (k == 5'd31);
  assign e_last = (e == EW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_SHIFT;
      ST_SHIFT:  if (k_last && e_last) state_nxt = ST_COMMIT;
      ST_COMMIT: if (k_last) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k       <= '0;
      e       <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      ev_q    <= '0;
      slice_q <= '0;
    end else begin
      if (accept) begin
        data_q  <= req_data;
        keep_q  <= req_keep;
        ev_q    <= req_entry_valid;
        slice_q <= req_slice;
      end
      if (state == ST_SHIFT || state == ST_COMMIT) k <= k + 5'd1;
      else                                         k <= '0;
      if (state == ST_SHIFT && k_last) e <= e_last ? '0 : e + EW'(1);
      else if (state != ST_SHIFT)      e <= '0;
    end
  end

  // Entry mux uses constant indices so the per-block slices stay static.
  always_comb begin
    cur_data  = '0;
    cur_keep  = '0;
    cur_ev    = 1'b0;
    blk_match = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (e == EW'(i)) begin
        cur_data = data_q[i*TCAM_WIDTH +: TCAM_WIDTH];
        cur_keep = keep_q[i*TCAM_WIDTH +: TCAM_WIDTH];
        cur_ev   = ev_q[i];
      end
    end
    for (int unsigned b = 0; b < B; b++) begin
      blk_match[b] = cur_ev & ~|(cur_keep[b*5 +: 5] & (cur_data[b*5 +: 5] ^ k));
    end
  end

  // Bit 31 ends up holding the match for k=0, so COMMIT reads addresses in order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < B*N; i++) stage[i] <= '0;
    end else if (state == ST_SHIFT) begin
      for (int unsigned b = 0; b < B; b++) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (e == EW'(i)) stage[b*N+i] <= {stage[b*N+i][30:0], blk_match[b]};
        end
      end
    end else if (state == ST_COMMIT) begin
      for (int unsigned i = 0; i < B*N; i++) stage[i] <= {stage[i][30:0], 1'b0};
    end
  end

  always_comb begin
    req_ready    = (state == ST_IDLE);
    busy         = (state != ST_IDLE);
    done         = (state == ST_DONE);
    error        = (state == ST_DONE) && !(32'(slice_q) < S);
    wr_addr      = search_key;
    wr_data_in   = '0;
    wr_enable_oh = '0;
    if (state == ST_SHIFT || state == ST_COMMIT) wr_addr = {B{k}};
    if (state == ST_COMMIT) begin
      for (int unsigned i = 0; i < B*N; i++) wr_data_in[i] = stage[i][31];
      for (int unsigned s = 0; s < S; s++) begin
        if (32'(slice_q) == s) wr_enable_oh[s] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tcam_update_engine.sv
// Bench for tcam_update_engine: per-cycle comparison against a timeline model
// of each request, plus directed scenarios with hand-computed expectations.
module tb_tcam_update_engine;

  localparam int W  = 10;
  localparam int N  = 4;
  localparam int B  = 2;
  localparam int S  = 3;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   search_key;
  logic           req_valid;
  logic           req_ready;
  logic [W*N-1:0] req_data;
  logic [W*N-1:0] req_keep;
  logic [N-1:0]   req_entry_valid;
  logic [1:0]     req_slice;
  logic [W-1:0]   wr_addr;
  logic [B*N-1:0] wr_data_in;
  logic [S-1:0]   wr_enable_oh;
  logic           busy;
  logic           done;
  logic           error;

  tcam_update_engine #(
    .TCAM_WIDTH(10),
    .TCAM_DEPTH(12),
    .ENTRIES_PER_SLICE(4),
    .SLICE_SEL_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .search_key(search_key),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data(req_data),
    .req_keep(req_keep),
    .req_entry_valid(req_entry_valid),
    .req_slice(req_slice),
    .wr_addr(wr_addr),
    .wr_data_in(wr_data_in),
    .wr_enable_oh(wr_enable_oh),
    .busy(busy),
    .done(done),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference: a request is a fixed 161-cycle timeline after acceptance;
  // cycle c in 1..128 expands, 129..160 writes address c-129, 161 reports.
  int          m_cnt = 0;
  int          m_slice = 0;
  logic [B*N-1:0] m_bits [32];

  function automatic logic tmatch(input logic [W-1:0] d, input logic [W-1:0] kp,
                                  input int b, input int k);
    for (int i = 0; i < 5; i++) begin
      if (kp[b*5+i] && (d[b*5+i] != k[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
    end else if (m_cnt == 0) begin
      if (req_valid) begin
        m_slice = int'(req_slice);
        for (int k = 0; k < 32; k++) begin
          for (int b = 0; b < B; b++) begin
            for (int e = 0; e < N; e++) begin
              m_bits[k][b*N+e] = req_entry_valid[e] &&
                tmatch(req_data[e*W +: W], req_keep[e*W +: W], b, k);
            end
          end
        end
        m_cnt = 1;
      end
    end else if (m_cnt == 161) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    logic          in_commit;
    logic [4:0]    kk;
    logic [W-1:0]  e_addr;
    logic [B*N-1:0] e_data;
    logic [S-1:0]  e_oh;
    in_commit = (m_cnt >= 129) && (m_cnt <= 160);
    kk        = 5'((m_cnt - 1) % 32);
    e_addr    = (m_cnt >= 1 && m_cnt <= 160) ? {kk, kk} : search_key;
    e_data    = in_commit ? m_bits[m_cnt-129] : '0;
    e_oh      = (in_commit && m_slice < S) ? S'(1 << m_slice) : '0;
    chk("req_ready", 40'(req_ready), 40'(m_cnt == 0));
    chk("busy", 40'(busy), 40'(m_cnt != 0));
    chk("done", 40'(done), 40'(m_cnt == 161));
    chk("error", 40'(error), 40'((m_cnt == 161) && (m_slice >= S)));
    chk("wr_addr", 40'(wr_addr), 40'(e_addr));
    chk("wr_data_in", 40'(wr_data_in), 40'(e_data));
    chk("wr_enable_oh", 40'(wr_enable_oh), 40'(e_oh));
  end

  int cyc = 0;

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #2;
    cyc += n;
    search_key = W'($urandom);
  endtask

  task automatic at(input int c);
    if (c > cyc) adv(c - cyc);
  endtask

  task automatic do_req(input logic [W*N-1:0] d, input logic [W*N-1:0] kp,
                        input logic [N-1:0] ev, input logic [1:0] sl);
    req_valid       = 1'b1;
    req_data        = d;
    req_keep        = kp;
    req_entry_valid = ev;
    req_slice       = sl;
    adv(1);
    cyc             = 1;
    req_valid       = 1'b0;
    req_data        = 40'({$urandom, $urandom});
    req_keep        = 40'({$urandom, $urandom});
    req_entry_valid = 4'($urandom);
    req_slice       = 2'($urandom);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [W*N-1:0] d;
    logic [W*N-1:0] kp;
    rst_n           = 1'b0;
    search_key      = '0;
    req_valid       = 1'b0;
    req_data        = '0;
    req_keep        = '0;
    req_entry_valid = '0;
    req_slice       = '0;
    adv(3);
    rst_n = 1'b1;
    adv(2);

    // Exact write: entry e = {e+1, e}
    for (int e = 0; e < N; e++) d[e*W +: W] = {5'(e + 1), 5'(e)};
    do_req(d, '1, 4'b1111, 2'd1);
    at(128);
    chk("lit_exact_oh_pre", 40'(wr_enable_oh), 40'(3'b000));
    at(129);
    chk("lit_exact_k0", 40'(wr_data_in), 40'(8'h01));
    chk("lit_exact_oh", 40'(wr_enable_oh), 40'(3'b010));
    at(130);
    chk("lit_exact_k1", 40'(wr_data_in), 40'(8'h12));
    at(133);
    chk("lit_exact_k4", 40'(wr_data_in), 40'(8'h80));
    at(160);
    chk("lit_exact_oh_last", 40'(wr_enable_oh), 40'(3'b010));
    at(161);
    chk("lit_exact_done", 40'(done), 40'(1));
    chk("lit_exact_err", 40'(error), 40'(0));
    at(162);
    chk("lit_exact_ready", 40'(req_ready), 40'(1));

    // Wildcard entry 2
    d  = 40'({$urandom, $urandom});
    kp = 40'({$urandom, $urandom});
    kp[2*W +: W] = '0;
    do_req(d, kp, 4'b1111, 2'd0);
    at(146);
    chk("lit_wild_k17", 40'(wr_data_in & 8'h44), 40'(8'h44));
    at(162);

    // Partial mask on entry 0 block 0
    d  = 40'({$urandom, $urandom});
    kp = 40'({$urandom, $urandom});
    d[0 +: W]  = 10'b00000_00110;
    kp[0 +: W] = 10'b00000_11110;
    do_req(d, kp, 4'b1111, 2'd2);
    at(134);
    chk("lit_part_k5", 40'(wr_data_in & 8'h11), 40'(8'h10));
    at(135);
    chk("lit_part_k6", 40'(wr_data_in & 8'h11), 40'(8'h11));
    at(136);
    chk("lit_part_k7", 40'(wr_data_in & 8'h11), 40'(8'h11));
    at(137);
    chk("lit_part_k8", 40'(wr_data_in & 8'h11), 40'(8'h10));
    at(162);

    // Invalidate entry 2 with all-wildcard data
    do_req(40'({$urandom, $urandom}), '0, 4'b1011, 2'd1);
    at(129);
    chk("lit_inv_k0", 40'(wr_data_in), 40'(8'hBB));
    at(160);
    chk("lit_inv_k31", 40'(wr_data_in), 40'(8'hBB));
    at(162);

    // Out-of-range slice
    do_req(40'({$urandom, $urandom}), '0, 4'b1111, 2'd3);
    at(140);
    chk("lit_oor_oh", 40'(wr_enable_oh), 40'(0));
    at(161);
    chk("lit_oor_done", 40'(done), 40'(1));
    chk("lit_oor_err", 40'(error), 40'(1));
    at(162);

    // Reset in the middle of SHIFT, then a clean request afterwards
    do_req('0, '0, 4'b1111, 2'd0);
    at(50);
    rst_n = 1'b0;
    #1;
    chk("lit_rst_ready", 40'(req_ready), 40'(1));
    chk("lit_rst_busy", 40'(busy), 40'(0));
    chk("lit_rst_oh", 40'(wr_enable_oh), 40'(0));
    chk("lit_rst_data", 40'(wr_data_in), 40'(0));
    chk("lit_rst_addr", 40'(wr_addr), 40'(search_key));
    adv(2);
    rst_n = 1'b1;
    adv(1);
    for (int e = 0; e < N; e++) d[e*W +: W] = {5'(e + 1), 5'(e)};
    do_req(d, '1, 4'b1111, 2'd2);
    at(129);
    chk("lit_post_rst_k0", 40'(wr_data_in), 40'(8'h01));
    chk("lit_post_rst_oh", 40'(wr_enable_oh), 40'(3'b100));
    at(162);

    // Random traffic; req_valid is also held during busy periods
    for (int i = 0; i < 1500; i++) begin
      adv(1);
      req_valid       = ($urandom_range(0, 3) == 0);
      req_data        = 40'({$urandom, $urandom});
      req_keep        = 40'({$urandom, $urandom}) & 40'({$urandom, $urandom});
      req_entry_valid = 4'($urandom);
      req_slice       = 2'($urandom);
      if (i == 700) begin
        rst_n = 1'b0;
        adv(3);
        rst_n = 1'b1;
      end
    end
    req_valid = 1'b0;
    adv(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
